// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage
package fetch_pkg;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HOLD} fetch_state_t;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0;
endpackage

// File: rtl/ifid_register.sv
// ifid_register: pipeline register with flush > hold > load priority, bubble when idle
module ifid_register
  import fetch_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         hold,
  input  logic         load,
  input  logic [W-1:0] instr_d,
  input  logic [W-1:0] pc_plus4_d,
  output logic         valid,
  output logic [W-1:0] instr,
  output logic [W-1:0] pc_plus4
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      instr    <= W'(NOP_INSTR);
      pc_plus4 <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (!hold) begin
      valid <= load;
      if (load) begin
        instr    <= instr_d;
        pc_plus4 <= pc_plus4_d;
      end
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding imem fetch FSM and IF/ID register
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imemReqValid,
  input  logic                  imemReqReady,
  output logic [DATA_WIDTH-1:0] imemReqAddr,
  input  logic                  imemRespValid,
  input  logic [DATA_WIDTH-1:0] imemRespData,
  input  logic                  idStall,
  input  logic                  redirectValid,
  input  logic [DATA_WIDTH-1:0] redirectTarget,
  output logic                  ifidValid,
  output logic [DATA_WIDTH-1:0] ifidInstr,
  output logic [DATA_WIDTH-1:0] ifidPcPlus4
);
  localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(INSTR_BYTES);
  fetch_state_t state, state_n;
  logic [DATA_WIDTH-1:0] pc, pc_n, req_pc, req_pc_n, hold_buf, hold_buf_n, target, rel_instr;
  logic rel;
  assign target       = redirectTarget & ~(DATA_WIDTH'(3));
  assign imemReqValid = (state == S_REQ) && !redirectValid;
  assign imemReqAddr  = pc;
  assign rel_instr    = (state == S_HOLD) ? hold_buf : imemRespData;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      req_pc   <= '0;
      hold_buf <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      req_pc   <= req_pc_n;
      hold_buf <= hold_buf_n;
    end
  end
  always_comb begin
    state_n    = state;
    pc_n       = redirectValid ? target : pc;
    req_pc_n   = req_pc;
    hold_buf_n = hold_buf;
    rel        = 1'b0;
    case (state)
      S_REQ: if (!redirectValid && imemReqReady) begin
        req_pc_n = pc;
        pc_n     = pc + STEP;
        state_n  = S_WAIT;
      end
      S_WAIT: begin
        if (imemRespValid) begin
          rel        = !redirectValid && !idStall;
          hold_buf_n = (!redirectValid && idStall) ? imemRespData : hold_buf;
          state_n    = (!redirectValid && idStall) ? S_HOLD : S_REQ;
        end else if (redirectValid) begin
          state_n = S_DROP;
        end
      end
      // a stale response is still owed; swallow it before fetching again
      S_DROP: state_n = imemRespValid ? S_REQ : S_DROP;
      S_HOLD: begin
        rel     = !redirectValid && !idStall;
        state_n = (redirectValid || !idStall) ? S_REQ : S_HOLD;
      end
      default: state_n = S_REQ;
    endcase
  end
  ifid_register #(.W(DATA_WIDTH)) u_ifid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirectValid),
    .hold      (idStall),
    .load      (rel),
    .instr_d   (rel_instr),
    .pc_plus4_d(req_pc + STEP),
    .valid     (ifidValid),
    .instr     (ifidInstr),
    .pc_plus4  (ifidPcPlus4)
  );
  a_resp_expected: assert property (@(posedge clk) disable iff (!rst_n)
    imemRespValid |-> (state == S_WAIT || state == S_DROP));
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table, corner sequences and randomized model check
module tb_fetch_stage;
  localparam logic [31:0] KEY = 32'h5A5A_0000;
  logic clk = 0, rst_n = 0, rst2_n = 0;
  logic imemReqValid, imemReqReady, imemRespValid, idStall, redirectValid, ifidValid;
  logic [31:0] imemReqAddr, imemRespData, redirectTarget, ifidInstr, ifidPcPlus4;
  logic req_v2, ready2, resp_v2, v2;
  logic [31:0] req_a2, resp_d2, instr2, pc4_2;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imemReqValid(imemReqValid), .imemReqReady(imemReqReady), .imemReqAddr(imemReqAddr),
    .imemRespValid(imemRespValid), .imemRespData(imemRespData),
    .idStall(idStall), .redirectValid(redirectValid), .redirectTarget(redirectTarget),
    .ifidValid(ifidValid), .ifidInstr(ifidInstr), .ifidPcPlus4(ifidPcPlus4)
  );

  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst2_n),
    .imemReqValid(req_v2), .imemReqReady(ready2), .imemReqAddr(req_a2),
    .imemRespValid(resp_v2), .imemRespData(resp_d2),
    .idStall(1'b0), .redirectValid(1'b0), .redirectTarget(32'h0),
    .ifidValid(v2), .ifidInstr(instr2), .ifidPcPlus4(pc4_2)
  );

  typedef struct {
    logic [31:0] rdy, rv, rd, st, rr, rt, erv, era, ev, ei, ep;
  } vec_t;
  vec_t vec [25];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    imemReqReady = 0; imemRespValid = 0; imemRespData = 0;
    idStall = 0; redirectValid = 0; redirectTarget = 0;
  endtask

  initial begin
    logic [31:0] exp_req, exp_del, pend_addr, p_rt, pi, pp;
    logic pv, p_rr, p_st, pending;
    int cd, deliveries;
    vec[0]  = '{1, 0, 32'h0,   0, 0, 32'h0,   1, 32'h0,   0, 32'h0,   32'h0};
    vec[1]  = '{0, 1, 32'h0,   0, 0, 32'h0,   0, 32'h0,   1, 32'h0,   32'h4};
    vec[2]  = '{1, 0, 32'h0,   0, 0, 32'h0,   1, 32'h4,   0, 32'h0,   32'h4};
    vec[3]  = '{0, 1, 32'h4,   0, 0, 32'h0,   0, 32'h0,   1, 32'h4,   32'h8};
    vec[4]  = '{1, 0, 32'h0,   0, 0, 32'h0,   1, 32'h8,   0, 32'h4,   32'h8};
    vec[5]  = '{0, 1, 32'h8,   1, 0, 32'h0,   0, 32'h0,   0, 32'h4,   32'h8};
    vec[6]  = '{1, 0, 32'h0,   1, 0, 32'h0,   0, 32'h0,   0, 32'h4,   32'h8};
    vec[7]  = '{1, 0, 32'h0,   1, 0, 32'h0,   0, 32'h0,   0, 32'h4,   32'h8};
    vec[8]  = '{0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   1, 32'h8,   32'hC};
    vec[9]  = '{1, 0, 32'h0,   0, 0, 32'h0,   1, 32'hC,   0, 32'h8,   32'hC};
    vec[10] = '{0, 0, 32'h0,   0, 1, 32'h103, 0, 32'h0,   0, 32'h8,   32'hC};
    vec[11] = '{0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h8,   32'hC};
    vec[12] = '{0, 1, 32'hC,   0, 0, 32'h0,   0, 32'h0,   0, 32'h8,   32'hC};
    vec[13] = '{1, 0, 32'h0,   0, 0, 32'h0,   1, 32'h100, 0, 32'h8,   32'hC};
    vec[14] = '{0, 1, 32'h100, 1, 1, 32'h200, 0, 32'h0,   0, 32'h8,   32'hC};
    vec[15] = '{1, 0, 32'h0,   0, 0, 32'h0,   1, 32'h200, 0, 32'h8,   32'hC};
    vec[16] = '{0, 1, 32'h200, 0, 0, 32'h0,   0, 32'h0,   1, 32'h200, 32'h204};
    vec[17] = '{1, 0, 32'h0,   0, 1, 32'h40,  0, 32'h0,   0, 32'h200, 32'h204};
    vec[18] = '{1, 0, 32'h0,   0, 0, 32'h0,   1, 32'h40,  0, 32'h200, 32'h204};
    vec[19] = '{0, 1, 32'h40,  1, 0, 32'h0,   0, 32'h0,   0, 32'h200, 32'h204};
    vec[20] = '{0, 0, 32'h0,   1, 1, 32'h80,  0, 32'h0,   0, 32'h200, 32'h204};
    vec[21] = '{1, 0, 32'h0,   0, 0, 32'h0,   1, 32'h80,  0, 32'h200, 32'h204};
    vec[22] = '{0, 1, 32'h80,  0, 0, 32'h0,   0, 32'h0,   1, 32'h80,  32'h84};
    vec[23] = '{0, 0, 32'h0,   1, 0, 32'h0,   1, 32'h84,  1, 32'h80,  32'h84};
    vec[24] = '{0, 0, 32'h0,   1, 1, 32'h300, 0, 32'h0,   0, 32'h80,  32'h84};
    idle;
    ready2 = 0; resp_v2 = 0; resp_d2 = 0;
    repeat (3) tick;
    chk("rst_ifid_valid", {31'b0, ifidValid}, 0);
    chk("rst_ifid_instr", ifidInstr, 0);
    chk("rst_ifid_pc4", ifidPcPlus4, 0);
    chk("rst_req_valid", {31'b0, imemReqValid}, 1);
    chk("rst_req_addr", imemReqAddr, 0);
    rst_n = 1;
    for (int i = 0; i < 25; i++) begin
      imemReqReady = vec[i].rdy[0]; imemRespValid = vec[i].rv[0]; imemRespData = vec[i].rd;
      idStall = vec[i].st[0]; redirectValid = vec[i].rr[0]; redirectTarget = vec[i].rt;
      #1;
      chk($sformatf("v%0d_req_valid", i), {31'b0, imemReqValid}, vec[i].erv);
      if (vec[i].erv[0]) chk($sformatf("v%0d_req_addr", i), imemReqAddr, vec[i].era);
      tick;
      chk($sformatf("v%0d_ifid_valid", i), {31'b0, ifidValid}, vec[i].ev);
      chk($sformatf("v%0d_ifid_instr", i), ifidInstr, vec[i].ei);
      chk($sformatf("v%0d_ifid_pc4", i), ifidPcPlus4, vec[i].ep);
    end
    // reset while a response is owed
    idle; imemReqReady = 1;
    #1 chk("rs_req_addr0", imemReqAddr, 32'h300);
    tick;
    idle; imemRespValid = 1; imemRespData = 32'h300;
    tick;
    chk("rs_loaded", {31'b0, ifidValid}, 1);
    idle; imemReqReady = 1;
    tick;
    idle;
    rst_n = 0;
    #1;
    chk("rs_valid", {31'b0, ifidValid}, 0);
    chk("rs_instr", ifidInstr, 0);
    chk("rs_pc4", ifidPcPlus4, 0);
    chk("rs_req_valid", {31'b0, imemReqValid}, 1);
    chk("rs_req_addr", imemReqAddr, 0);
    imemRespValid = 1; imemRespData = 32'hBAD0_0BAD;
    tick;
    idle;
    tick;
    rst_n = 1;
    #1;
    chk("rs_restart_valid", {31'b0, imemReqValid}, 1);
    chk("rs_restart_addr", imemReqAddr, 0);
    chk("rs_late_ignored", {31'b0, ifidValid}, 0);
    imemReqReady = 1;
    tick;
    idle; imemRespValid = 1; imemRespData = 32'h0;
    tick;
    chk("rs_first_valid", {31'b0, ifidValid}, 1);
    chk("rs_first_instr", ifidInstr, 0);
    chk("rs_first_pc4", ifidPcPlus4, 4);
    idle;
    // PC wrap at the top of the address space
    rst2_n = 1; ready2 = 1;
    #1;
    chk("wrap_req_valid", {31'b0, req_v2}, 1);
    chk("wrap_req_addr", req_a2, 32'hFFFF_FFFC);
    tick;
    ready2 = 0; resp_v2 = 1; resp_d2 = 32'hCAFE_0001;
    tick;
    chk("wrap_valid", {31'b0, v2}, 1);
    chk("wrap_instr", instr2, 32'hCAFE_0001);
    chk("wrap_pc4", pc4_2, 0);
    resp_v2 = 0; ready2 = 1;
    #1;
    chk("wrap_req2_addr", req_a2, 0);
    tick;
    ready2 = 0;
    // randomized run against a stream model
    rst_n = 0; idle;
    tick; tick;
    rst_n = 1;
    exp_req = 0; exp_del = 0; pending = 0; cd = 0; deliveries = 0;
    p_rr = 0; p_st = 0; p_rt = 0; pv = 0; pi = 0; pp = 0;
    for (int c = 0; c < 3000; c++) begin
      redirectValid = ($urandom % 16) == 0;
      redirectTarget = $urandom;
      idStall = ($urandom % 4) == 0;
      imemReqReady = ($urandom % 3) != 0;
      imemRespValid = 0;
      imemRespData = $urandom;
      if (pending) begin
        if (cd == 0) begin
          imemRespValid = 1; imemRespData = pend_addr ^ KEY; pending = 0;
        end else cd--;
      end
      #1;
      if (imemReqValid) begin
        chk("rnd_req_quiet", {30'b0, redirectValid, imemRespValid}, 0);
        if (imemReqReady) begin
          chk("rnd_req_addr", imemReqAddr, exp_req);
          exp_req += 4;
          pending = 1; pend_addr = imemReqAddr; cd = $urandom % 3;
        end
      end
      if (redirectValid) exp_req = redirectTarget & 32'hFFFF_FFFC;
      p_rr = redirectValid; p_st = idStall; p_rt = redirectTarget & 32'hFFFF_FFFC;
      tick;
      if (p_rr) begin
        chk("rnd_flush", {31'b0, ifidValid}, 0);
        exp_del = p_rt;
      end else if (p_st) begin
        chk("rnd_stall_valid", {31'b0, ifidValid}, {31'b0, pv});
        chk("rnd_stall_instr", ifidInstr, pi);
        chk("rnd_stall_pc4", ifidPcPlus4, pp);
      end else if (ifidValid) begin
        chk("rnd_instr", ifidInstr, exp_del ^ KEY);
        chk("rnd_pc4", ifidPcPlus4, exp_del + 4);
        exp_del += 4;
        deliveries++;
      end
      pv = ifidValid; pi = ifidInstr; pp = ifidPcPlus4;
    end
    chk("rnd_progress", {31'b0, deliveries >= 100}, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
